// File: rtl/alarm_ctrl_pkg.sv
// Shared types and limits for the digital clock blocks.
package clock_pkg;
  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } alarm_state_t;

  localparam int MAX_SEC = 59;
  localparam int MAX_MIN = 59;
  localparam int MAX_HR  = 23;
endpackage

// File: rtl/alarm_ctrl_if.sv
// Time inputs, user pulses and alarm outputs of the alarm controller.
interface alarm_ctrl_if;
  logic       tick_sec;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       edit_en;
  logic       field_sel;
  logic       up_pressed;
  logic       down_pressed;
  logic       toggle_pressed;
  logic       stop_pressed;
  logic       snooze_pressed;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hr;
  logic [1:0] alarm_state;
  logic       ringing;
  logic       beep;

  modport master (
    output tick_sec, seconds, minutes, hours, edit_en, field_sel,
           up_pressed, down_pressed, toggle_pressed, stop_pressed, snooze_pressed,
    input  alarm_min, alarm_hr, alarm_state, ringing, beep
  );

  modport slave (
    input  tick_sec, seconds, minutes, hours, edit_en, field_sel,
           up_pressed, down_pressed, toggle_pressed, stop_pressed, snooze_pressed,
    output alarm_min, alarm_hr, alarm_state, ringing, beep
  );
endinterface

// File: rtl/alarm_ctrl_updown.sv
// Modulo-(MAX+1) up/down register; inc and dec together cancel out.
module mod_updown #(
  parameter int W       = 6,
  parameter int MAX     = 59,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] MAXV = W'(MAX);
  localparam logic [W-1:0] RSTV = W'(RST_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= RSTV;
    else if (en && inc && !dec)
      q <= (q == MAXV) ? '0 : q + 1'b1;
    else if (en && dec && !inc)
      q <= (q == '0) ? MAXV : q - 1'b1;
  end
endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: editable alarm time plus arm/ring/snooze sequencing.
// Build option ALARM_BEEP_EN pulses beep at 0.5 Hz instead of holding it steady.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int DEF_HR     = 7,
  parameter int DEF_MIN    = 0
) (
  input logic         CLOCK_50,
  input logic         reset,
  alarm_ctrl_if.slave bus
);
  localparam logic [7:0]  RING_LAST = 8'(RING_SECS - 1);
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60 - 1);

  logic [5:0]   min_q;
  logic [4:0]   hr_q;
  alarm_state_t state_q, state_d;
  logic [7:0]   ring_q, ring_d;
  logic [11:0]  snz_q, snz_d;
  logic         ringing_q, beep_q, beep_d;
  logic         match;

  mod_updown #(.W(6), .MAX(MAX_MIN), .RST_VAL(DEF_MIN)) u_min (
    .clk(CLOCK_50), .rst(reset), .en(bus.edit_en & ~bus.field_sel),
    .inc(bus.up_pressed), .dec(bus.down_pressed), .q(min_q)
  );

  mod_updown #(.W(5), .MAX(MAX_HR), .RST_VAL(DEF_HR)) u_hr (
    .clk(CLOCK_50), .rst(reset), .en(bus.edit_en & bus.field_sel),
    .inc(bus.up_pressed), .dec(bus.down_pressed), .q(hr_q)
  );

  // Compares against the registered alarm, so a same-cycle edit is not yet visible.
  assign match = bus.tick_sec && (bus.seconds == 6'd0) &&
                 (bus.minutes == min_q) && (bus.hours == hr_q);

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    case (state_q)
      DISARMED: if (bus.toggle_pressed) state_d = ARMED;
      ARMED: begin
        if (bus.toggle_pressed) state_d = DISARMED;
        else if (match) begin
          state_d = RINGING;
          ring_d  = '0;
        end
      end
      RINGING: begin
        if (bus.toggle_pressed)      state_d = DISARMED;
        else if (bus.stop_pressed)   state_d = ARMED;
        else if (bus.snooze_pressed) begin
          state_d = SNOOZE;
          snz_d   = SNZ_LOAD;
        end else if (bus.tick_sec) begin
          ring_d = ring_q + 8'd1;
          if (ring_q == RING_LAST) state_d = ARMED;
        end
      end
      SNOOZE: begin
        if (bus.toggle_pressed)    state_d = DISARMED;
        else if (bus.stop_pressed) state_d = ARMED;
        else if (bus.tick_sec) begin
          if (snz_q == '0) begin
            state_d = RINGING;
            ring_d  = '0;
          end else begin
            snz_d = snz_q - 12'd1;
          end
        end
      end
      default: state_d = DISARMED;
    endcase
  end

`ifdef ALARM_BEEP_EN
  logic phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (state_d == RINGING) begin
      if (state_q != RINGING) phase_d = 1'b1;
      else if (bus.tick_sec)  phase_d = ~phase_q;
    end
    beep_d = (state_d == RINGING) & phase_d;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) phase_q <= 1'b0;
    else       phase_q <= phase_d;
  end
`else
  always_comb beep_d = (state_d == RINGING);
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= DISARMED;
      ring_q    <= '0;
      snz_q     <= '0;
      ringing_q <= 1'b0;
      beep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_d;
      snz_q     <= snz_d;
      ringing_q <= (state_d == RINGING);
      beep_q    <= beep_d;
    end
  end

  assign bus.alarm_min   = min_q;
  assign bus.alarm_hr    = hr_q;
  assign bus.alarm_state = state_q;
  assign bus.ringing     = ringing_q;
  assign bus.beep        = beep_q;
endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm controller for the digital clock. It holds a user-set alarm time (hours/minutes) that is edited with the same debounced up/down pulses used for time-setting. It compares the alarm time against the live time-holder outputs once per second and sequences the alarm through arm, ring, snooze and stop states. It sits beside the time holder: it consumes the 1 Hz tick and the current time, and drives the LEDs and an alarm indicator.

Parameters:
RING_SECS, 60, seconds RINGING lasts before auto-timeout to ARMED (1..255)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
DEF_HR, 7, alarm hour loaded at reset (0..23)
DEF_MIN, 0, alarm minute loaded at reset (0..59)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
tick_sec  in  1  one-cycle pulse, once per second
seconds  in  6  current seconds, 0..59
minutes  in  6  current minutes, 0..59
hours  in  5  current hours, 0..23
edit_en  in  1  level; alarm-set mode active
field_sel  in  1  0 = edit minutes, 1 = edit hours
up_pressed  in  1  one-cycle pulse
down_pressed  in  1  one-cycle pulse
toggle_pressed  in  1  one-cycle pulse; arm/disarm
stop_pressed  in  1  one-cycle pulse
snooze_pressed  in  1  one-cycle pulse
alarm_min  out  6  stored alarm minute
alarm_hr  out  5  stored alarm hour
alarm_state  out  2  encoded FSM state
ringing  out  1  high in RINGING
beep  out  1  gated ring output (see Optional Feature)

Behaviour:
- Reset (async, active-high): alarm_hr=DEF_HR, alarm_min=DEF_MIN, state DISARMED, ring_cnt=0, snz_cnt=0. Outputs: ringing=0, beep=0, alarm_state=DISARMED.
- All outputs are registered. State changes become visible the cycle after the triggering input.
- States and encodings: DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3.
- Match condition: tick_sec && seconds==0 && minutes==alarm_min && hours==alarm_hr. Inputs and registered alarm values are sampled in the same cycle.
- DISARMED:
  - toggle -> ARMED.
  - Match is ignored.
- ARMED:
  - toggle -> DISARMED.
  - Match -> RINGING, with ring_cnt=0.
- RINGING:
  - Each tick_sec increments ring_cnt. When the tick arrives with ring_cnt==RING_SECS-1 -> ARMED.
  - stop -> ARMED.
  - snooze -> SNOOZE, with snz_cnt=SNOOZE_MIN*60-1 (12-bit counter).
  - toggle -> DISARMED.
- SNOOZE:
  - Each tick_sec decrements snz_cnt. A tick with snz_cnt==0 -> RINGING, with ring_cnt=0.
  - stop -> ARMED.
  - toggle -> DISARMED.
  - Match is ignored.
- Priority when events coincide in one cycle: toggle > stop > snooze > tick/match.
- Edit, active only when edit_en=1 (any state):
  - up: increments the selected field; down: decrements it.
  - Minutes wrap 59->0 and 0->59. Hours wrap 23->0 and 0->23.
  - up and down in the same cycle: no change.
  - Edits never carry between fields.
  - An edit and a match in the same cycle: the match uses the pre-edit value.
  - Editing does not change the FSM state and does not stop ringing.
- Ring and snooze counters hold their value in states that do not use them.

Optional Feature:
ALARM_BEEP_EN
- Defined:
  - beep = ringing & beep_phase.
  - beep_phase is set to 1 on entry to RINGING and toggles on each tick_sec while RINGING, giving a 0.5 Hz on/off pattern.
- Undefined:
  - beep = ringing (steady).
  - No beep_phase register exists.
- The port exists in both builds.

Decomposition:
- Package clock_pkg:
  - alarm_state_t enum (DISARMED, ARMED, RINGING, SNOOZE; 2-bit).
  - Constants MAX_SEC=59, MAX_MIN=59, MAX_HR=23.
- Sub-module mod_updown:
  - Parameterised-width register with modulus MAX, inputs inc/dec/en and async reset value.
  - Instantiated twice, for alarm_min and alarm_hr.

Test Plan:
- Reset mid-RINGING -> next cycle alarm_state=0, ringing=0, alarm_hr=7, alarm_min=0.
- Edit wrap (edit_en=1):
  - field_sel=0, alarm_min=59, up -> 0.
  - field_sel=1, alarm_hr=0, down -> 23.
  - up+down together -> unchanged.
- Armed match at 07:00:00 tick -> ringing=1 next cycle. After 60 ticks -> ARMED, ringing=0. The same time while DISARMED -> stays 0.
- RINGING, snooze, SNOOZE_MIN=1 -> state 3. 59 ticks: still SNOOZE. 60th tick -> RINGING.
- Simultaneous toggle+stop in RINGING -> DISARMED. stop+snooze -> ARMED.
- ALARM_BEEP_EN defined: beep is 1,0,1 across the first three seconds of RINGING. Undefined: beep is steady 1.
